// File: rtl/spi_reg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_reg_pkg : shared types and frame constants for the SPI bridge  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package spi_reg_pkg;

  localparam int CMD_BITS   = 8;
  localparam int FRAME_BITS = 16;
  localparam int WR_RDN_POS = 15;
  // Position of the write flag inside the command byte.
  localparam int CMD_WR_BIT = WR_RDN_POS - (FRAME_BITS - CMD_BITS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_DATA    = 3'd3,
    ST_WR_REQ  = 3'd4,
    ST_WAIT_CS = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_edge_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_edge_sync : 2-FF pad synchronizers and sclk edge detection     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic spi_cs_n,
  input  logic spi_sclk,
  input  logic spi_mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [1:0] cs_q;
  logic [1:0] sclk_q;
  logic [1:0] mosi_q;
  logic       sclk_d;

  // cs_n resets deselected so a reset never looks like a frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q   <= 2'b11;
      sclk_q <= 2'b00;
      mosi_q <= 2'b00;
      sclk_d <= 1'b0;
    end else begin
      cs_q   <= {cs_q[0], spi_cs_n};
      sclk_q <= {sclk_q[0], spi_sclk};
      mosi_q <= {mosi_q[0], spi_mosi};
      sclk_d <= sclk_q[1];
    end
  end

  assign cs_n_s    = cs_q[1];
  assign mosi_s    = mosi_q[1];
  assign sclk_rise = sclk_q[1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[1] & sclk_d;

endmodule
`default_nettype wire

// File: rtl/spi_reg_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | spi_reg_initiator : SPI mode-0 frames to single-beat reg accesses  |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module spi_reg_initiator
  import spi_reg_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int REG_W   = 8,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              wr_rdn,
  output logic [ADDR_W-1:0] addr,
  output logic [REG_W-1:0]  wdata,
  output logic              we,
  input  logic [REG_W-1:0]  rdata,
  input  logic              ack,
  input  logic              err,
  output logic              err_sticky,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  state_t             state;
  logic               cs_n_s, mosi_s, sclk_rise, sclk_fall;
  logic [BIT_W-1:0]   bit_cnt;
  logic [REG_W-2:0]   shreg;
  logic [REG_W-1:0]   rx_byte;
  logic [REG_W-2:0]   miso_sr;
  logic               miso_q;
  logic               is_write;
  logic               pending;
  logic [CNT_W-1:0]   tcnt;
  logic               ack_hit, timeout_hit, abort;

  spi_edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .cs_n_s    (cs_n_s),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  assign rx_byte     = {shreg, mosi_s};
  assign ack_hit     = pending & ack;
  assign timeout_hit = pending & ~ack & (tcnt == CNT_W'(TIMEOUT - 1));
  assign abort       = (state != ST_IDLE) & (cs_n_s | ~ena);
  assign spi_miso    = miso_q & ena;
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      miso_sr    <= '0;
      miso_q     <= 1'b0;
      is_write   <= 1'b0;
      pending    <= 1'b0;
      tcnt       <= '0;
      wr_rdn     <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      we         <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      we <= 1'b0;

      // The outstanding request is tracked independently of the frame so an
      // aborted or late transaction still completes before the next frame.
      if (pending) begin
        if (ack) begin
          pending <= 1'b0;
          if (err) err_sticky <= 1'b1;
        end else if (timeout_hit) begin
          pending    <= 1'b0;
          err_sticky <= 1'b1;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end

      if (abort && state != ST_WAIT_CS) begin
        miso_q  <= 1'b0;
        bit_cnt <= '0;
        state   <= pending ? ST_WAIT_CS : ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (!cs_n_s && ena) begin
              bit_cnt <= '0;
              state   <= ST_CMD;
            end
          end

          ST_CMD: begin
            if (sclk_rise) begin
              shreg   <= rx_byte[REG_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_W'(CMD_BITS - 1)) begin
                addr     <= rx_byte[ADDR_W-1:0];
                is_write <= rx_byte[CMD_WR_BIT];
                if (rx_byte[CMD_WR_BIT]) begin
                  state <= ST_DATA;
                end else begin
                  wr_rdn  <= 1'b0;
                  we      <= 1'b1;
                  pending <= 1'b1;
                  tcnt    <= '0;
                  state   <= ST_RD_REQ;
                end
              end
            end
          end

          ST_RD_REQ: begin
            if (ack_hit) begin
              miso_sr <= rdata[REG_W-2:0];
              miso_q  <= rdata[REG_W-1];
              state   <= ST_DATA;
            end else if (timeout_hit || sclk_fall) begin
              // A fall here is the first data-bit launch: too late for rdata.
              if (sclk_fall) err_sticky <= 1'b1;
              miso_sr <= '0;
              miso_q  <= 1'b0;
              state   <= ST_DATA;
            end
          end

          ST_DATA: begin
            if (sclk_rise) begin
              shreg   <= rx_byte[REG_W-2:0];
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                miso_q <= 1'b0;
                if (is_write) begin
                  wdata   <= rx_byte;
                  wr_rdn  <= 1'b1;
                  we      <= 1'b1;
                  pending <= 1'b1;
                  tcnt    <= '0;
                  state   <= ST_WR_REQ;
                end else begin
                  state <= ST_WAIT_CS;
                end
              end
            end else if (sclk_fall && !is_write && bit_cnt > BIT_W'(CMD_BITS)) begin
              miso_q  <= miso_sr[REG_W-2];
              miso_sr <= {miso_sr[REG_W-3:0], 1'b0};
            end
          end

          ST_WR_REQ: begin
            if (ack_hit || timeout_hit) state <= ST_WAIT_CS;
          end

          ST_WAIT_CS: begin
            if ((cs_n_s || !ena) && !pending) state <= ST_IDLE;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_reg_initiator.md
Name: spi_reg_initiator

Overview:
- SPI mode-0 peripheral front end that turns 16-bit SPI frames into single-beat transactions toward the register bank's application interface.
- Drives wr_rdn/addr/wdata/we on that interface, consumes rdata/ack/err, and returns read data on MISO.
- SPI pins are oversampled in the clk domain; no sclk-domain logic.
- Sits between the chip's SPI pads and the register bank.

Parameters:
ADDR_W, 7, register address width; must be ≤ 7 (address field of command byte).
REG_W, 8, register data width; fixed to the 8-bit data byte of the frame.
TIMEOUT, 8, clk cycles to wait for ack before declaring a bus error.

Ports:
clk  input  1  system clock; must be ≥ 16x spi_sclk frequency.
rst  input  1  reset; asynchronous, active-high.
ena  input  1  block enable; when low, SPI is ignored and MISO is held 0.
spi_cs_n  input  1  chip select, active-low, asynchronous to clk.
spi_sclk  input  1  SPI clock, asynchronous to clk.
spi_mosi  input  1  serial data in.
spi_miso  output  1  serial data out.
wr_rdn  output  1  1 = write, 0 = read; valid while we is high.
addr  output  ADDR_W  register address.
wdata  output  REG_W  write data.
we  output  1  transaction strobe, one-cycle pulse, qualified by wr_rdn.
rdata  input  REG_W  read data; valid with ack.
ack  input  1  transaction complete.
err  input  1  responder error; valid with ack.
err_sticky  output  1  set on responder err, timeout or late read; cleared only by rst.
busy  output  1  high from cs_n fall until return to IDLE.

Behaviour:
- Reset values: spi_miso=0, wr_rdn=0, addr=0, wdata=0, we=0, err_sticky=0, busy=0; FSM goes to IDLE.
- Input sync: 2-FF synchronizers on cs_n, sclk and mosi. sclk rise/fall are detected from the synchronized value plus one delay register. Detection latency is 3 clk after the pad edge.
- Frame format, MSB first: bit15 = wr_rdn, bits14:8 = address (low ADDR_W bits used, upper bits ignored), bits7:0 = data. Data is MOSI for a write and MISO for a read.
- MOSI is sampled on a detected sclk rise. MISO shift register advances on a detected sclk fall.
- FSM states:
  - IDLE: wait for cs_n low.
  - CMD: shift in 8 bits.
  - RD_REQ: issue read; wait for ack or timeout.
  - DATA: shift 8 bits.
  - WR_REQ: issue write; wait for ack or timeout.
  - WAIT_CS: wait for cs_n high.
- Transitions:
  - IDLE→CMD: cs_n low and ena high.
  - CMD→RD_REQ: 8th bit sampled with bit15=0. we pulses on the next cycle with addr latched.
  - CMD→DATA: 8th bit sampled with bit15=1.
  - RD_REQ→DATA: ack received. rdata is loaded into the MISO shift register; spi_miso is driven with rdata[7] immediately.
  - DATA→WR_REQ: 16th bit sampled on a write. we pulses with wdata.
  - DATA→WAIT_CS: 16th bit on a read.
  - WR_REQ→WAIT_CS: ack received or timeout.
  - WAIT_CS→IDLE: cs_n high.
- Timeout: a counter runs from the we pulse. If ack is absent for TIMEOUT cycles, set err_sticky and continue. A read that times out returns 0x00.
- Late read: if the 8th sclk fall (first data-bit launch) is detected before ack, set err_sticky and shift 0x00. A later ack is ignored.
- Responder error: ack with err=1 sets err_sticky. The returned data is still shifted out.
- we is never asserted more than once per frame. No new request is issued while one is outstanding.
- cs_n high mid-frame, in any state: abort to IDLE, or to WAIT_CS-equivalent completion if a request is outstanding, on the cycle after detection.
  - Partial frames never generate a we pulse.
  - An outstanding request still waits for ack or timeout before returning to IDLE; a new cs_n fall in that window is ignored until IDLE.
- Extra sclk edges after bit 16 are ignored; spi_miso holds 0.
- ena low forces IDLE at the next cycle, with the same rules as cs_n abort.
- rst asserted mid-frame: all state and outputs return to reset values immediately.

Decomposition:
- Shared package spi_reg_pkg holds:
  - the state enum type;
  - CMD_BITS=8 and FRAME_BITS=16;
  - the bit position of the wr_rdn flag.
- One natural sub-module, spi_edge_sync: 2-FF synchronizers plus rise/fall detect for sclk, and the synchronized cs_n/mosi.

Test Plan:
- Write frame 0x85,0x3C (addr 0x05, data 0x3C), responder acks in 2 cycles → exactly one we pulse with wr_rdn=1, addr=0x05, wdata=0x3C; err_sticky=0.
- Read frame 0x12,0x00, responder returns rdata=0xA5 with ack after 1 cycle → one we pulse with wr_rdn=0, addr=0x12; MISO bits during data byte = 1,0,1,0,0,1,0,1.
- Write with ack never asserted, TIMEOUT=8 → err_sticky rises exactly 8 cycles after we; FSM reaches IDLE after cs_n high.
- Read with responder ack delayed past 8th sclk fall → MISO data byte = 0x00, err_sticky=1, no second we pulse.
- cs_n deasserted after 5 command bits → no we pulse, busy falls; next full write frame 0x81,0xFF succeeds normally.
- rst pulsed during data phase of a write → no we pulse, all outputs at reset values; ack with err=1 on a later frame → err_sticky=1.
